m_cu_addr_gen: RTL and testbench

// - Memory control unit front end: accepts one load/store command at a time from the scheduler
//   (mcu_* handshake), walks vl elements and emits one memory request per element.
// - Sits between scheduler and the memory port; sequences store data from the vector lanes
//   and tracks outstanding load responses so the scheduler can see when a load is buffered.

---
 rtl/m_cu_addr_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_m_cu_addr_gen.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cu_addr_gen.sv
// -----------------------------------------------------------------------------
// m_cu_addr_gen
// Memory control unit front end. Accepts one load/store command at a time from
// the scheduler, walks the element count and emits one memory request per
// element. Store requests are paced by the lanes presenting store data. Load
// requests are limited by the number of responses still outstanding.
//
// Optional feature macro: INDEXED_LD_ST_EN
//   defined     : indexed mode is legal, element address = base + idx_data_i
//   not defined : an indexed command is rejected with an err_o pulse;
//                 idx_rdy_o is tied low and the idx_* inputs are unused
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   mcu_*_i / mcu_*_o    scheduler command handshake and command fields
//   vl_i                 element count, sampled with the command
//   mcu_ld_buffered_o    no load requests outstanding or still to be issued
//   req_*                memory request port (valid/ready, addr, we, size)
//   st_data_vld_i/rdy_o  store element handshake with the vector lanes
//   rsp_vld_i            one load response returned
//   idx_*                index element handshake (indexed mode only)
//   err_o                one-cycle pulse: illegal command dropped
// -----------------------------------------------------------------------------
module m_cu_addr_gen #(
  parameter int VLEN      = 4096,
  parameter int VLANE_NUM = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mcu_ld_vld_i,
  input  logic        mcu_st_vld_i,
  input  logic [31:0] mcu_base_addr_i,
  input  logic [31:0] mcu_stride_i,
  input  logic [2:0]  mcu_data_width_i,
  input  logic        mcu_unit_ld_st_i,
  input  logic        mcu_strided_ld_st_i,
  input  logic        mcu_idx_ld_st_i,
  input  logic [31:0] vl_i,
  output logic        mcu_ld_rdy_o,
  output logic        mcu_st_rdy_o,
  output logic        mcu_ld_buffered_o,
  output logic        req_vld_o,
  input  logic        req_rdy_i,
  output logic [31:0] req_addr_o,
  output logic        req_we_o,
  output logic [1:0]  req_size_o,
  input  logic        st_data_vld_i,
  output logic        st_data_rdy_o,
  input  logic        rsp_vld_i,
  input  logic        idx_vld_i,
  input  logic [31:0] idx_data_i,
  output logic        idx_rdy_o,
  output logic        err_o
);

  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam logic [OW-1:0] MAX_OUTST_Q = OW'(MAX_OUTST);
  // Largest element count a vector register group can hold (VLEN*8 bits / 8).
  localparam logic [31:0] MAX_ELEM = 32'(VLEN);
  // Lane count only documents the surrounding datapath.
  localparam int unused_lanes_lp = VLANE_NUM;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [31:0]  base_q, base_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  step_q, step_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [1:0]   size_q, size_d;
  logic         we_q, we_d;
  logic         idx_q, idx_d;
  logic         err_q, err_d;
  logic [OW-1:0] outst_q, outst_d;

  logic         cmd_vld_s;
  logic         width_ok_s;
  logic         mode_ok_s;
  logic [1:0]   dec_size_s;
  logic         rsp_eff_s;
  logic         room_s;
  logic         elem_rdy_s;
  logic         fire_s;
  logic         ld_fire_s;

  // Decode the RVV width code and check that exactly one legal mode bit is set.
  always_comb begin
    dec_size_s = 2'd0;
    width_ok_s = 1'b1;
    mode_ok_s  = 1'b0;
    case (mcu_data_width_i)
      3'b000:  dec_size_s = 2'd0;
      3'b101:  dec_size_s = 2'd1;
      3'b110:  dec_size_s = 2'd2;
      default: width_ok_s = 1'b0;
    endcase
    case ({mcu_idx_ld_st_i, mcu_strided_ld_st_i, mcu_unit_ld_st_i})
      3'b001:  mode_ok_s = 1'b1;
      3'b010:  mode_ok_s = 1'b1;
`ifdef INDEXED_LD_ST_EN
      3'b100:  mode_ok_s = 1'b1;
`else
      3'b100:  mode_ok_s = 1'b0;
`endif
      default: mode_ok_s = 1'b0;
    endcase
  end

  assign cmd_vld_s = (mcu_ld_vld_i | mcu_st_vld_i) & (state_q == S_IDLE);

  // A response arriving with nothing outstanding is stale and ignored; a valid
  // same-cycle response frees a slot for a new load request.
  assign rsp_eff_s = rsp_vld_i & (outst_q != '0);
  assign room_s    = (outst_q < MAX_OUTST_Q) | rsp_eff_s;

  // Per-element readiness: stores wait for lane data, loads for a free slot.
  always_comb begin
    elem_rdy_s = we_q ? st_data_vld_i : room_s;
`ifdef INDEXED_LD_ST_EN
    if (idx_q) begin
      elem_rdy_s = idx_vld_i & (we_q ? st_data_vld_i : room_s);
    end else begin
      elem_rdy_s = we_q ? st_data_vld_i : room_s;
    end
`endif
  end

  assign fire_s    = req_vld_o & req_rdy_i;
  assign ld_fire_s = fire_s & ~we_q;

  // Outstanding load counter: simultaneous issue and response cancel out.
  always_comb begin
    outst_d = outst_q;
    if (ld_fire_s && !rsp_eff_s) begin
      outst_d = outst_q + OW'(1);
    end else if (!ld_fire_s && rsp_eff_s) begin
      outst_d = outst_q - OW'(1);
    end else begin
      outst_d = outst_q;
    end
  end

  // Next-state logic: command capture, element walk and drain of load responses.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    we_d    = we_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_vld_s) begin
          if (!(width_ok_s && mode_ok_s)) begin
            err_d = 1'b1;
          end else if (vl_i != 32'd0) begin
            state_d = S_ISSUE;
            base_d  = mcu_base_addr_i;
            addr_d  = mcu_base_addr_i;
            step_d  = mcu_strided_ld_st_i ? mcu_stride_i : (32'd1 << dec_size_s);
            cnt_d   = (vl_i > MAX_ELEM) ? MAX_ELEM : vl_i;
            size_d  = dec_size_s;
            we_d    = ~mcu_ld_vld_i;
            idx_d   = mcu_idx_ld_st_i;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (fire_s) begin
          cnt_d  = cnt_q - 32'd1;
          addr_d = addr_q + step_q;
          if (cnt_q == 32'd1) begin
            state_d = (!we_q && (outst_d != '0)) ? S_DRAIN : S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (outst_d == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      base_q  <= 32'd0;
      addr_q  <= 32'd0;
      step_q  <= 32'd0;
      cnt_q   <= 32'd0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      idx_q   <= 1'b0;
      err_q   <= 1'b0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      outst_q <= outst_d;
    end
  end

  assign mcu_ld_rdy_o      = (state_q == S_IDLE);
  assign mcu_st_rdy_o      = (state_q == S_IDLE) & ~mcu_ld_vld_i;
  assign mcu_ld_buffered_o = ((state_q != S_ISSUE) | we_q) & (outst_q == '0);
  assign req_vld_o         = (state_q == S_ISSUE) & elem_rdy_s;
  assign req_we_o          = we_q;
  assign req_size_o        = size_q;
  assign st_data_rdy_o     = fire_s & we_q;
  assign err_o             = err_q;

`ifdef INDEXED_LD_ST_EN
  assign req_addr_o = ((state_q == S_ISSUE) && idx_q) ? (base_q + idx_data_i) : addr_q;
  assign idx_rdy_o  = fire_s & idx_q;
  logic unused_s;
  assign unused_s = 1'b0;
`else
  assign req_addr_o = addr_q;
  assign idx_rdy_o  = 1'b0;
  logic unused_s;
  assign unused_s = ^{idx_vld_i, idx_data_i, base_q, idx_q};
`endif

endmodule

// File: tb/tb_m_cu_addr_gen.sv
// -----------------------------------------------------------------------------
// Testbench for m_cu_addr_gen. Commands are driven one at a time, memory ready,
// lane data and responses are randomised, and every fired request is compared
// with an address list computed as base + i*step (or base + index).
// -----------------------------------------------------------------------------
module tb_m_cu_addr_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mcu_ld_vld_i, mcu_st_vld_i;
  logic [31:0] mcu_base_addr_i, mcu_stride_i, vl_i;
  logic [2:0]  mcu_data_width_i;
  logic        mcu_unit_ld_st_i, mcu_strided_ld_st_i, mcu_idx_ld_st_i;
  logic        mcu_ld_rdy_o, mcu_st_rdy_o, mcu_ld_buffered_o;
  logic        req_vld_o, req_rdy_i, req_we_o;
  logic [31:0] req_addr_o;
  logic [1:0]  req_size_o;
  logic        st_data_vld_i, st_data_rdy_o, rsp_vld_i;
  logic        idx_vld_i, idx_rdy_o, err_o;
  logic [31:0] idx_data_i;

  always #5 clk = ~clk;

  m_cu_addr_gen dut (
    .clk(clk), .rstn(rstn),
    .mcu_ld_vld_i(mcu_ld_vld_i), .mcu_st_vld_i(mcu_st_vld_i),
    .mcu_base_addr_i(mcu_base_addr_i), .mcu_stride_i(mcu_stride_i),
    .mcu_data_width_i(mcu_data_width_i), .mcu_unit_ld_st_i(mcu_unit_ld_st_i),
    .mcu_strided_ld_st_i(mcu_strided_ld_st_i), .mcu_idx_ld_st_i(mcu_idx_ld_st_i),
    .vl_i(vl_i), .mcu_ld_rdy_o(mcu_ld_rdy_o), .mcu_st_rdy_o(mcu_st_rdy_o),
    .mcu_ld_buffered_o(mcu_ld_buffered_o), .req_vld_o(req_vld_o),
    .req_rdy_i(req_rdy_i), .req_addr_o(req_addr_o), .req_we_o(req_we_o),
    .req_size_o(req_size_o), .st_data_vld_i(st_data_vld_i),
    .st_data_rdy_o(st_data_rdy_o), .rsp_vld_i(rsp_vld_i),
    .idx_vld_i(idx_vld_i), .idx_data_i(idx_data_i), .idx_rdy_o(idx_rdy_o),
    .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] obs_addr[$];
  logic [1:0]  obs_size[$];
  logic        obs_we[$];
  logic [31:0] idx_list[$];
  int          st_rdy_cnt, idx_rdy_cnt, err_cnt;
  logic        last_fire;
  logic        seen_ld_rdy, seen_st_rdy;

  localparam logic [2:0] M_UNIT = 3'b001;
  localparam logic [2:0] M_STRD = 3'b010;
  localparam logic [2:0] M_IDX  = 3'b100;

  // Reference address of element i: plain modulo-2^32 arithmetic.
  function automatic logic [31:0] model_addr(input logic [31:0] base,
                                             input logic [31:0] stp, input int i);
    return base + stp * 32'(i);
  endfunction

  function automatic logic [1:0] model_size(input logic [2:0] w);
    return (w == 3'b000) ? 2'd0 : (w == 3'b101) ? 2'd1 : 2'd2;
  endfunction

  task automatic clear_obs();
    obs_addr.delete(); obs_size.delete(); obs_we.delete();
    st_rdy_cnt = 0; idx_rdy_cnt = 0; err_cnt = 0;
  endtask

  task automatic send_cmd(input logic ld, input logic st, input logic [31:0] base,
                          input logic [31:0] stride, input logic [2:0] w,
                          input logic [2:0] mode, input logic [31:0] vl);
    @(posedge clk); #1;
    mcu_ld_vld_i = ld; mcu_st_vld_i = st;
    mcu_base_addr_i = base; mcu_stride_i = stride; mcu_data_width_i = w;
    {mcu_idx_ld_st_i, mcu_strided_ld_st_i, mcu_unit_ld_st_i} = mode;
    vl_i = vl;
    req_rdy_i = 1'b0; rsp_vld_i = 1'b0; st_data_vld_i = 1'b0; idx_vld_i = 1'b0;
    @(negedge clk);
    seen_ld_rdy = mcu_ld_rdy_o;
    seen_st_rdy = mcu_st_rdy_o;
  endtask

  task automatic step(input logic rdy, input logic stv, input logic rsp,
                      input logic iv, input logic [31:0] id);
    @(posedge clk); #1;
    mcu_ld_vld_i = 1'b0; mcu_st_vld_i = 1'b0;
    req_rdy_i = rdy; st_data_vld_i = stv; rsp_vld_i = rsp;
    idx_vld_i = iv; idx_data_i = id;
    @(negedge clk);
    last_fire = req_vld_o & req_rdy_i;
    if (last_fire) begin
      obs_addr.push_back(req_addr_o);
      obs_size.push_back(req_size_o);
      obs_we.push_back(req_we_o);
    end
    if (st_data_rdy_o) st_rdy_cnt++;
    if (idx_rdy_o) idx_rdy_cnt++;
    if (err_o) err_cnt++;
  endtask

  // Run n element requests with random ready/data; loads get a response lat
  // cycles after each fire. Stops once all requests and responses are done.
  task automatic run(input int n, input int rdy_pct, input int stv_pct,
                     input logic is_ld, input int lat, input int budget);
    int cyc = 0;
    int fires = 0;
    int due[$];
    logic rsp, rdy, stv;
    logic [31:0] id;
    while ((fires < n || due.size() != 0) && cyc < budget) begin
      rsp = 1'b0;
      if (due.size() != 0 && due[0] <= cyc) begin
        rsp = 1'b1;
        void'(due.pop_front());
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      stv = ($urandom_range(0, 99) < stv_pct);
      id  = (fires < idx_list.size()) ? idx_list[fires] : 32'h0;
      step(rdy, stv, rsp, 1'b1, id);
      if (last_fire) begin
        fires++;
        if (is_ld) due.push_back(cyc + lat);
      end
      cyc++;
    end
    checks++;
    if (fires < n || due.size() != 0) begin
      failures++;
      $display("FAIL run_timeout fires=%0d required=%0d pending_rsp=%0d", fires, n, due.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    mcu_ld_vld_i = 1'b0; mcu_st_vld_i = 1'b0; mcu_base_addr_i = 32'h0;
    mcu_stride_i = 32'h0; mcu_data_width_i = 3'b000; mcu_unit_ld_st_i = 1'b0;
    mcu_strided_ld_st_i = 1'b0; mcu_idx_ld_st_i = 1'b0; vl_i = 32'h0;
    req_rdy_i = 1'b0; st_data_vld_i = 1'b0; rsp_vld_i = 1'b0;
    idx_vld_i = 1'b0; idx_data_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_vld_o, st_data_rdy_o, idx_rdy_o, err_o, req_we_o} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {req_vld_o, st_data_rdy_o, idx_rdy_o, err_o, req_we_o});
    end
    checks++;
    if (req_addr_o !== 32'h0 || req_size_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_addr got=%h/%0d exp=0/0", req_addr_o, req_size_o);
    end
    checks++;
    if ({mcu_ld_rdy_o, mcu_st_rdy_o, mcu_ld_buffered_o} !== 3'b111) begin
      failures++;
      $display("FAIL reset_rdy got=%b exp=111", {mcu_ld_rdy_o, mcu_st_rdy_o, mcu_ld_buffered_o});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_unit_load();
    clear_obs();
    send_cmd(1'b1, 1'b0, 32'h1000, 32'h0, 3'b110, M_UNIT, 32'd4);
    run(4, 100, 0, 1'b1, 2, 50);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_addr.size() != 4) begin
      failures++;
      $display("FAIL unit_ld_count got=%0d exp=4", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++;
      if (obs_addr[i] !== model_addr(32'h1000, 32'd4, i) || obs_size[i] !== 2'd2 || obs_we[i] !== 1'b0) begin
        failures++;
        $display("FAIL unit_ld_req[%0d] got=%h/%0d/%b exp=%h/2/0", i, obs_addr[i], obs_size[i],
                 obs_we[i], model_addr(32'h1000, 32'd4, i));
      end
    end
    checks++;
    if (mcu_ld_buffered_o !== 1'b1 || mcu_ld_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL unit_ld_done got=%b%b exp=11", mcu_ld_buffered_o, mcu_ld_rdy_o);
    end
  endtask

  task automatic test_strided_store();
    clear_obs();
    send_cmd(1'b0, 1'b1, 32'h20, 32'hFFFF_FFF8, 3'b000, M_STRD, 32'd3);
    run(3, 100, 50, 1'b0, 1, 100);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_addr.size() != 3 || st_rdy_cnt != 3) begin
      failures++;
      $display("FAIL st_count got=%0d/%0d exp=3/3", obs_addr.size(), st_rdy_cnt);
    end
    for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
      checks++;
      if (obs_addr[i] !== model_addr(32'h20, 32'hFFFF_FFF8, i) || obs_size[i] !== 2'd0 || obs_we[i] !== 1'b1) begin
        failures++;
        $display("FAIL st_req[%0d] got=%h/%0d/%b exp=%h/0/1", i, obs_addr[i], obs_size[i],
                 obs_we[i], model_addr(32'h20, 32'hFFFF_FFF8, i));
      end
    end
  endtask

  task automatic test_max_outst();
    clear_obs();
    send_cmd(1'b1, 1'b0, 32'h300, 32'h0, 3'b000, M_UNIT, 32'd12);
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_addr.size() != 8 || req_vld_o !== 1'b0 || mcu_ld_buffered_o !== 1'b0) begin
      failures++;
      $display("FAIL max_outst got=%0d vld=%b buf=%b exp=8 vld=0 buf=0",
               obs_addr.size(), req_vld_o, mcu_ld_buffered_o);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (last_fire !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_rsp got=%b exp=1", last_fire);
    end
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    run(3, 100, 0, 1'b1, 2, 50);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_addr.size() != 12 || mcu_ld_buffered_o !== 1'b1) begin
      failures++;
      $display("FAIL max_outst_total got=%0d buf=%b exp=12 buf=1", obs_addr.size(), mcu_ld_buffered_o);
    end
    for (int i = 0; i < obs_addr.size() && i < 12; i++) begin
      checks++;
      if (obs_addr[i] !== model_addr(32'h300, 32'd1, i)) begin
        failures++;
        $display("FAIL max_outst_addr[%0d] got=%h exp=%h", i, obs_addr[i], model_addr(32'h300, 32'd1, i));
      end
    end
  endtask

  task automatic test_ld_st_collision();
    clear_obs();
    send_cmd(1'b1, 1'b1, 32'h40, 32'h0, 3'b000, M_UNIT, 32'd2);
    checks++;
    if (seen_ld_rdy !== 1'b1 || seen_st_rdy !== 1'b0) begin
      failures++;
      $display("FAIL collide_rdy got=%b%b exp=10", seen_ld_rdy, seen_st_rdy);
    end
    run(2, 100, 100, 1'b1, 1, 50);
    send_cmd(1'b0, 1'b1, 32'h80, 32'h0, 3'b101, M_UNIT, 32'd2);
    run(2, 100, 100, 1'b0, 1, 50);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_addr.size() != 4) begin
      failures++;
      $display("FAIL collide_count got=%0d exp=4", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 32'h40 || obs_addr[1] !== 32'h41 || obs_we[0] !== 1'b0 || obs_we[1] !== 1'b0) begin
        failures++;
        $display("FAIL collide_ld got=%h,%h we=%b%b exp=40,41 we=00", obs_addr[0], obs_addr[1], obs_we[0], obs_we[1]);
      end
      checks++;
      if (obs_addr[2] !== 32'h80 || obs_addr[3] !== 32'h82 || obs_we[2] !== 1'b1 || obs_size[3] !== 2'd1) begin
        failures++;
        $display("FAIL collide_st got=%h,%h we=%b size=%0d exp=80,82 we=1 size=1",
                 obs_addr[2], obs_addr[3], obs_we[2], obs_size[3]);
      end
    end
  endtask

  task automatic test_errors();
    clear_obs();
    send_cmd(1'b1, 1'b0, 32'h0, 32'h0, 3'b111, M_UNIT, 32'd4);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (err_cnt != 1 || obs_addr.size() != 0 || mcu_ld_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL err_width got=%0d/%0d/%b exp=1/0/1", err_cnt, obs_addr.size(), mcu_ld_rdy_o);
    end
    clear_obs();
    send_cmd(1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 3'b011, 32'd4);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (err_cnt != 1 || obs_addr.size() != 0) begin
      failures++;
      $display("FAIL err_mode got=%0d/%0d exp=1/0", err_cnt, obs_addr.size());
    end
    clear_obs();
    send_cmd(1'b1, 1'b0, 32'h0, 32'h0, 3'b110, M_UNIT, 32'd0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (err_cnt != 0 || obs_addr.size() != 0 || mcu_ld_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL vl_zero got=%0d/%0d/%b exp=0/0/1", err_cnt, obs_addr.size(), mcu_ld_rdy_o);
    end
  endtask

  task automatic test_wrap();
    clear_obs();
    send_cmd(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 3'b110, M_UNIT, 32'd2);
    run(2, 100, 0, 1'b1, 1, 50);
    checks++;
    if (obs_addr.size() != 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=2", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 32'hFFFF_FFFC || obs_addr[1] !== 32'h0) begin
        failures++;
        $display("FAIL wrap_addr got=%h,%h exp=fffffffc,00000000", obs_addr[0], obs_addr[1]);
      end
    end
  endtask

  task automatic test_indexed();
    clear_obs();
    idx_list.delete();
    idx_list.push_back(32'h8);
    idx_list.push_back(32'h0);
    send_cmd(1'b1, 1'b0, 32'h100, 32'h0, 3'b110, M_IDX, 32'd2);
`ifdef INDEXED_LD_ST_EN
    run(2, 100, 0, 1'b1, 1, 50);
    checks++;
    if (obs_addr.size() != 2 || idx_rdy_cnt != 2 || err_cnt != 0) begin
      failures++;
      $display("FAIL idx_count got=%0d/%0d/%0d exp=2/2/0", obs_addr.size(), idx_rdy_cnt, err_cnt);
    end else begin
      checks++;
      if (obs_addr[0] !== 32'h108 || obs_addr[1] !== 32'h100) begin
        failures++;
        $display("FAIL idx_addr got=%h,%h exp=108,100", obs_addr[0], obs_addr[1]);
      end
    end
`else
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
    checks++;
    if (err_cnt != 1 || obs_addr.size() != 0 || idx_rdy_cnt != 0) begin
      failures++;
      $display("FAIL idx_disabled got=%0d/%0d/%0d exp=1/0/0", err_cnt, obs_addr.size(), idx_rdy_cnt);
    end
`endif
    idx_list.delete();
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_cmd(1'b1, 1'b0, 32'h2000, 32'h0, 3'b110, M_UNIT, 32'd10);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_vld_o !== 1'b0 || req_addr_o !== 32'h0 || {mcu_ld_rdy_o, mcu_st_rdy_o, mcu_ld_buffered_o} !== 3'b111) begin
      failures++;
      $display("FAIL reset_mid got=%b/%h/%b exp=0/0/111", req_vld_o, req_addr_o,
               {mcu_ld_rdy_o, mcu_st_rdy_o, mcu_ld_buffered_o});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (mcu_ld_buffered_o !== 1'b1 || req_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_stale_rsp got=%b%b exp=10", mcu_ld_buffered_o, req_vld_o);
    end
  endtask

  task automatic test_random();
    logic        ld, strd;
    logic [2:0]  w;
    logic [31:0] base, stride, stp;
    int          vl, sel;
    for (int t = 0; t < 12; t++) begin
      clear_obs();
      ld     = 1'($urandom_range(0, 1));
      strd   = 1'($urandom_range(0, 1));
      sel    = $urandom_range(0, 2);
      w      = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b101 : 3'b110;
      base   = $urandom;
      stride = 32'($urandom_range(0, 64)) - 32'd32;
      vl     = $urandom_range(1, 10);
      stp    = strd ? stride : (32'd1 << model_size(w));
      send_cmd(ld, ~ld, base, stride, w, strd ? M_STRD : M_UNIT, 32'(vl));
      run(vl, 60, 60, ld, $urandom_range(1, 4), 400);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_addr.size() != vl || st_rdy_cnt != (ld ? 0 : vl)) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d/%0d exp=%0d/%0d", t, obs_addr.size(), st_rdy_cnt,
                 vl, ld ? 0 : vl);
      end
      for (int i = 0; i < obs_addr.size() && i < vl; i++) begin
        checks++;
        if (obs_addr[i] !== model_addr(base, stp, i) || obs_size[i] !== model_size(w) || obs_we[i] !== ~ld) begin
          failures++;
          $display("FAIL rand%0d_req[%0d] got=%h/%0d/%b exp=%h/%0d/%b", t, i, obs_addr[i],
                   obs_size[i], obs_we[i], model_addr(base, stp, i), model_size(w), ~ld);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit_load();
    test_strided_store();
    test_max_outst();
    test_ld_st_collision();
    test_errors();
    test_wrap();
    test_indexed();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
